// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - opcodes, ALU encodings, FSM states and control word for control_unit
package cpu_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;

  typedef enum logic [3:0] {
    RST_ST, FETCH0, FETCH1, FETCH2, EX3, EX4, EX5, EX6, EX7, HALTED
  } state_t;

  // One bit per strobe plus the ALU function and the run flag
  typedef struct packed {
    logic       Gra;
    logic       Grb;
    logic       Grc;
    logic       Rin;
    logic       Rout;
    logic       BAout;
    logic       Cout;
    logic       PCout;
    logic       PCin;
    logic       IncPC;
    logic       MARin;
    logic       MDRin;
    logic       MDRout;
    logic       IRin;
    logic       Yin;
    logic       Zin;
    logic       Zlowout;
    logic       CONin;
    logic       Read;
    logic       Write;
    logic [3:0] alu_op;
    logic       run;
  } ctrl_t;

  // Register-register ALU instructions
  function automatic logic is_alu_rr(input logic [4:0] op);
    is_alu_rr = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
  endfunction

  // Loads and stores share the address-computation steps EX3..EX5
  function automatic logic is_mem(input logic [4:0] op);
    is_mem = (op == OP_LD) || (op == OP_ST);
  endfunction

  function automatic logic [3:0] alu_of(input logic [4:0] op);
    case (op)
      OP_SUB:  alu_of = ALU_SUB;
      OP_AND:  alu_of = ALU_AND;
      OP_OR:   alu_of = ALU_OR;
      default: alu_of = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/control_unit.sv
// rtl/control_unit.sv - Moore control FSM: fetch, per-opcode execute steps, halt
module control_unit
  import cpu_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic [4:0] opcode,
  input  logic       con_ff,
  input  logic       mem_done,
  output logic       Gra,
  output logic       Grb,
  output logic       Grc,
  output logic       Rin,
  output logic       Rout,
  output logic       BAout,
  output logic       Cout,
  output logic       PCout,
  output logic       PCin,
  output logic       IncPC,
  output logic       MARin,
  output logic       MDRin,
  output logic       MDRout,
  output logic       IRin,
  output logic       Yin,
  output logic       Zin,
  output logic       Zlowout,
  output logic       CONin,
  output logic       Read,
  output logic       Write,
  output logic [3:0] alu_op,
  output logic       run
);

  state_t     state, nxt;
  logic [4:0] op_q, op_nxt;
  ctrl_t      ctrl_q;

  // Control word for a state; f1_entry marks the first FETCH1 cycle, br_take the branch decision
  function automatic ctrl_t decode(input state_t s, input logic [4:0] op,
                                   input logic f1_entry, input logic br_take);
    ctrl_t c;
    c        = '0;
    c.alu_op = ALU_ADD;
    c.run    = (s != RST_ST) && (s != HALTED);
    case (s)
      FETCH0: begin c.PCout = 1'b1; c.MARin = 1'b1; c.IncPC = 1'b1; c.Zin = 1'b1; end
      FETCH1: begin c.Zlowout = 1'b1; c.PCin = f1_entry; c.Read = 1'b1; c.MDRin = 1'b1; end
      FETCH2: begin c.MDRout = 1'b1; c.IRin = 1'b1; end
      EX3: begin
        if (is_alu_rr(op) || op == OP_ADDI || is_mem(op)) begin
          c.Grb   = 1'b1;
          c.Yin   = 1'b1;
          c.BAout = is_mem(op);
          c.Rout  = !is_mem(op);
        end else if (op == OP_BR) begin
          c.Gra = 1'b1; c.Rout = 1'b1; c.CONin = 1'b1;
        end
      end
      EX4: begin
        if (is_alu_rr(op)) begin
          c.Grc = 1'b1; c.Rout = 1'b1; c.Zin = 1'b1; c.alu_op = alu_of(op);
        end else if (op == OP_BR) begin
          c.PCout = 1'b1; c.Yin = 1'b1;
        end else begin
          c.Cout = 1'b1; c.Zin = 1'b1;
        end
      end
      EX5: begin
        if (op == OP_BR) begin
          c.Cout = 1'b1; c.Zin = 1'b1;
        end else begin
          c.Zlowout = 1'b1;
          c.MARin   = is_mem(op);
          c.Gra     = !is_mem(op);
          c.Rin     = !is_mem(op);
        end
      end
      EX6: begin
        if (op == OP_LD) begin
          c.Read = 1'b1; c.MDRin = 1'b1;
        end else if (op == OP_ST) begin
          c.Gra = 1'b1; c.Rout = 1'b1; c.MDRin = 1'b1;
        end else begin
          c.Zlowout = br_take; c.PCin = br_take;
        end
      end
      EX7: begin
        if (op == OP_LD) begin
          c.MDRout = 1'b1; c.Gra = 1'b1; c.Rin = 1'b1;
        end else begin
          c.Write = 1'b1;
        end
      end
      default: ;
    endcase
    decode = c;
  endfunction

  // Next state; the opcode becomes visible to the decode on the FETCH2 -> EX3 step
  always_comb begin
    op_nxt = (state == FETCH2) ? opcode : op_q;
    nxt    = state;
    case (state)
      RST_ST: nxt = FETCH0;
      FETCH0: nxt = FETCH1;
      FETCH1: nxt = mem_done ? FETCH2 : FETCH1;
      FETCH2: nxt = EX3;
      EX3: begin
        if (op_q == OP_HALT)
          nxt = HALTED;
        else if (is_alu_rr(op_q) || op_q == OP_ADDI || is_mem(op_q) || op_q == OP_BR)
          nxt = EX4;
        else
          nxt = FETCH0;
      end
      EX4: nxt = EX5;
      EX5: nxt = (is_mem(op_q) || op_q == OP_BR) ? EX6 : FETCH0;
      EX6: begin
        if (op_q == OP_LD)
          nxt = mem_done ? EX7 : EX6;
        else if (op_q == OP_ST)
          nxt = EX7;
        else
          nxt = FETCH0;
      end
      EX7: nxt = (op_q == OP_ST && !mem_done) ? EX7 : FETCH0;
      HALTED: nxt = HALTED;
      default: nxt = RST_ST;
    endcase
  end

  // State, latched opcode and registered control word (decoded from the state being entered)
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state  <= RST_ST;
      op_q   <= '0;
      ctrl_q <= '0;
    end else begin
      state  <= nxt;
      op_q   <= op_nxt;
      ctrl_q <= decode(nxt, op_nxt, state != FETCH1, con_ff);
    end
  end

  assign Gra     = ctrl_q.Gra;
  assign Grb     = ctrl_q.Grb;
  assign Grc     = ctrl_q.Grc;
  assign Rin     = ctrl_q.Rin;
  assign Rout    = ctrl_q.Rout;
  assign BAout   = ctrl_q.BAout;
  assign Cout    = ctrl_q.Cout;
  assign PCout   = ctrl_q.PCout;
  assign PCin    = ctrl_q.PCin;
  assign IncPC   = ctrl_q.IncPC;
  assign MARin   = ctrl_q.MARin;
  assign MDRin   = ctrl_q.MDRin;
  assign MDRout  = ctrl_q.MDRout;
  assign IRin    = ctrl_q.IRin;
  assign Yin     = ctrl_q.Yin;
  assign Zin     = ctrl_q.Zin;
  assign Zlowout = ctrl_q.Zlowout;
  assign CONin   = ctrl_q.CONin;
  assign Read    = ctrl_q.Read;
  assign Write   = ctrl_q.Write;
  assign alu_op  = ctrl_q.alu_op;
  assign run     = ctrl_q.run;

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - randomized self-checking bench for control_unit
module tb_control_unit;

  logic       clock = 1'b0;
  logic       reset_n, con_ff, mem_done;
  logic [4:0] opcode;
  logic Gra, Grb, Grc, Rin, Rout, BAout, Cout, PCout, PCin, IncPC, MARin, MDRin;
  logic MDRout, IRin, Yin, Zin, Zlowout, CONin, Read, Write, run;
  logic [3:0] alu_op;
  logic [24:0] obs;

  int total = 0;
  int bad   = 0;

  control_unit dut (
    .clock(clock), .reset_n(reset_n), .opcode(opcode), .con_ff(con_ff), .mem_done(mem_done),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout), .Cout(Cout),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout),
    .IRin(IRin), .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout), .CONin(CONin), .Read(Read),
    .Write(Write), .alu_op(alu_op), .run(run)
  );

  always #5 clock = ~clock;

  assign obs = {Gra, Grb, Grc, Rin, Rout, BAout, Cout, PCout, PCin, IncPC, MARin, MDRin,
                MDRout, IRin, Yin, Zin, Zlowout, CONin, Read, Write, alu_op, run};

  localparam logic [24:0] B_GRA  = 25'h1 << 24, B_GRB  = 25'h1 << 23, B_GRC   = 25'h1 << 22;
  localparam logic [24:0] B_RIN  = 25'h1 << 21, B_ROUT = 25'h1 << 20, B_BAOUT = 25'h1 << 19;
  localparam logic [24:0] B_COUT = 25'h1 << 18, B_PCOUT = 25'h1 << 17, B_PCIN = 25'h1 << 16;
  localparam logic [24:0] B_INC  = 25'h1 << 15, B_MARIN = 25'h1 << 14, B_MDRIN = 25'h1 << 13;
  localparam logic [24:0] B_MDROUT = 25'h1 << 12, B_IRIN = 25'h1 << 11, B_YIN = 25'h1 << 10;
  localparam logic [24:0] B_ZIN  = 25'h1 << 9, B_ZLOW = 25'h1 << 8, B_CONIN = 25'h1 << 7;
  localparam logic [24:0] B_READ = 25'h1 << 6, B_WRITE = 25'h1 << 5, B_RUN = 25'h1;
  localparam logic [24:0] W_F0 = B_PCOUT | B_MARIN | B_INC | B_ZIN | B_RUN;

  localparam logic [1:0] MD_0 = 2'd0, MD_1 = 2'd1, MD_RND = 2'd2;

  // One expected clock cycle: control word, mem_done to present, opcode to present
  typedef struct {
    logic [24:0] exp;
    logic [1:0]  md;
    logic        opv;
    logic [4:0]  opc;
  } step_t;

  step_t q[$];

  task automatic push(input logic [24:0] m, input logic [1:0] md);
    step_t s;
    s.exp = m | B_RUN;
    s.md  = md;
    s.opv = 1'b0;
    s.opc = 5'd0;
    q.push_back(s);
  endtask

  // Expected cycle-by-cycle control words of one instruction, from FETCH0 to its last step
  task automatic build(input logic [4:0] op, input logic con, input int fw, input int mw);
    int last;
    logic [24:0] addr3;
    q.delete();
    push(B_PCOUT | B_MARIN | B_INC | B_ZIN, MD_RND);
    for (int w = 0; w <= fw; w++)
      push(B_ZLOW | B_READ | B_MDRIN | ((w == 0) ? B_PCIN : 25'h0), (w == fw) ? MD_1 : MD_0);
    push(B_MDROUT | B_IRIN, MD_RND);
    last = q.size() - 1;
    q[last].opv = 1'b1;
    q[last].opc = op;
    addr3 = B_GRB | B_BAOUT | B_YIN;
    case (op)
      5'b00011, 5'b00100, 5'b00101, 5'b00110: begin
        push(B_GRB | B_ROUT | B_YIN, MD_RND);
        push(B_GRC | B_ROUT | B_ZIN | (25'(op - 5'd3) << 1), MD_RND);
        push(B_ZLOW | B_GRA | B_RIN, MD_RND);
      end
      5'b01100: begin
        push(B_GRB | B_ROUT | B_YIN, MD_RND);
        push(B_COUT | B_ZIN, MD_RND);
        push(B_ZLOW | B_GRA | B_RIN, MD_RND);
      end
      5'b00000: begin
        push(addr3, MD_RND); push(B_COUT | B_ZIN, MD_RND); push(B_ZLOW | B_MARIN, MD_RND);
        for (int w = 0; w <= mw; w++) push(B_READ | B_MDRIN, (w == mw) ? MD_1 : MD_0);
        push(B_MDROUT | B_GRA | B_RIN, MD_RND);
      end
      5'b00010: begin
        push(addr3, MD_RND); push(B_COUT | B_ZIN, MD_RND); push(B_ZLOW | B_MARIN, MD_RND);
        push(B_GRA | B_ROUT | B_MDRIN, MD_RND);
        for (int w = 0; w <= mw; w++) push(B_WRITE, (w == mw) ? MD_1 : MD_0);
      end
      5'b10010: begin
        push(B_GRA | B_ROUT | B_CONIN, MD_RND);
        push(B_PCOUT | B_YIN, MD_RND);
        push(B_COUT | B_ZIN, MD_RND);
        push(con ? (B_ZLOW | B_PCIN) : 25'h0, MD_RND);
      end
      default: push(25'h0, MD_RND);
    endcase
  endtask

  task automatic drive(input step_t s);
    mem_done = (s.md == MD_RND) ? 1'($urandom) : s.md[0];
    opcode   = s.opv ? s.opc : 5'($urandom);
    @(posedge clock);
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    mem_done = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; mem_done = 1'b0; con_ff = 1'b0; opcode = 5'd0;
    tick();
    tick();
    total++;
    if (obs !== 25'h0) begin bad++; $display("FAIL reset_outputs got %h want %h", obs, 25'h0); end
    reset_n = 1'b1;
    tick();
    total++;
    if (obs !== W_F0) begin bad++; $display("FAIL reset_release got %h want %h", obs, W_F0); end
  endtask

  task automatic test_add();
    apply_reset();
    con_ff = 1'b0;
    build(5'b00011, 1'b0, 0, 0);
    total++;
    if (q.size() != 6) begin bad++; $display("FAIL add_len got %0d want 6", q.size()); end
    foreach (q[i]) begin
      total++;
      if (obs !== q[i].exp) begin bad++; $display("FAIL add step %0d got %h want %h", i, obs, q[i].exp); end
      drive(q[i]);
    end
    total++;
    if (obs !== W_F0) begin bad++; $display("FAIL add_return got %h want %h", obs, W_F0); end
  endtask

  task automatic test_ld_slow();
    build(5'b00000, 1'b0, 0, 3);
    foreach (q[i]) begin
      total++;
      if (obs !== q[i].exp) begin bad++; $display("FAIL ld_slow step %0d got %h want %h", i, obs, q[i].exp); end
      drive(q[i]);
    end
    total++;
    if (obs !== W_F0) begin bad++; $display("FAIL ld_return got %h want %h", obs, W_F0); end
  endtask

  task automatic test_br();
    for (int c = 0; c < 2; c++) begin
      con_ff = 1'(c);
      build(5'b10010, 1'(c), c, 0);
      foreach (q[i]) begin
        total++;
        if (obs !== q[i].exp) begin bad++; $display("FAIL br con=%0d step %0d got %h want %h", c, i, obs, q[i].exp); end
        drive(q[i]);
      end
      total++;
      if (obs !== W_F0) begin bad++; $display("FAIL br_return con=%0d got %h want %h", c, obs, W_F0); end
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] ops [8] = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b01100, 5'b00010, 5'b00000, 5'b10101};
    for (int k = 0; k < 8; k++) begin
      con_ff = 1'($urandom);
      build(ops[k], con_ff, $urandom_range(0, 2), $urandom_range(0, 2));
      foreach (q[i]) begin
        total++;
        if (obs !== q[i].exp) begin bad++; $display("FAIL b2b op=%b step %0d got %h want %h", ops[k], i, obs, q[i].exp); end
        drive(q[i]);
      end
    end
    total++;
    if (obs !== W_F0) begin bad++; $display("FAIL b2b_return got %h want %h", obs, W_F0); end
  endtask

  task automatic test_random();
    logic [4:0] known [9] = '{5'b00000, 5'b00010, 5'b00011, 5'b00100, 5'b00101,
                              5'b00110, 5'b01100, 5'b10010, 5'b11011};
    logic [4:0] op;
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 4) == 0) begin
        op = 5'($urandom);
        while (op inside {known}) op = 5'($urandom);
      end else begin
        op = known[$urandom_range(0, 7)];
      end
      con_ff = 1'($urandom);
      build(op, con_ff, $urandom_range(0, 3), $urandom_range(0, 3));
      foreach (q[i]) begin
        total++;
        if (obs !== q[i].exp) begin bad++; $display("FAIL random op=%b step %0d got %h want %h", op, i, obs, q[i].exp); end
        drive(q[i]);
      end
    end
    total++;
    if (obs !== W_F0) begin bad++; $display("FAIL random_return got %h want %h", obs, W_F0); end
  endtask

  task automatic test_reset_wait();
    int n;
    apply_reset();
    build(5'b00010, 1'b0, 0, 6);
    n = q.size() - 3;
    for (int i = 0; i < n; i++) begin
      total++;
      if (obs !== q[i].exp) begin bad++; $display("FAIL st_wait step %0d got %h want %h", i, obs, q[i].exp); end
      drive(q[i]);
    end
    total++;
    if (obs !== (B_WRITE | B_RUN)) begin bad++; $display("FAIL st_in_wait got %h want %h", obs, B_WRITE | B_RUN); end
    reset_n = 1'b0; mem_done = 1'b0;
    tick();
    total++;
    if (obs !== 25'h0) begin bad++; $display("FAIL st_wait_reset got %h want %h", obs, 25'h0); end
    reset_n = 1'b1;
    tick();
    total++;
    if (obs !== W_F0) begin bad++; $display("FAIL st_wait_refetch got %h want %h", obs, W_F0); end
    build(5'b00011, 1'b0, 4, 0);
    for (int i = 0; i < 3; i++) drive(q[i]);
    total++;
    if (obs !== (B_ZLOW | B_READ | B_MDRIN | B_RUN)) begin bad++; $display("FAIL fetch_wait got %h want %h", obs, B_ZLOW | B_READ | B_MDRIN | B_RUN); end
    reset_n = 1'b0;
    tick();
    total++;
    if (obs !== 25'h0) begin bad++; $display("FAIL fetch_reset got %h want %h", obs, 25'h0); end
    reset_n = 1'b1;
    tick();
    total++;
    if (obs !== W_F0) begin bad++; $display("FAIL fetch_refetch got %h want %h", obs, W_F0); end
  endtask

  task automatic test_halt();
    build(5'b11011, 1'b0, 1, 0);
    foreach (q[i]) begin
      total++;
      if (obs !== q[i].exp) begin bad++; $display("FAIL halt step %0d got %h want %h", i, obs, q[i].exp); end
      drive(q[i]);
    end
    for (int c = 0; c < 21; c++) begin
      total++;
      if (obs !== 25'h0) begin bad++; $display("FAIL halted cycle %0d got %h want %h", c, obs, 25'h0); end
      mem_done = 1'($urandom);
      opcode   = 5'($urandom);
      tick();
    end
    reset_n = 1'b0;
    tick();
    total++;
    if (obs !== 25'h0) begin bad++; $display("FAIL halt_reset got %h want %h", obs, 25'h0); end
    reset_n = 1'b1;
    tick();
    total++;
    if (obs !== W_F0) begin bad++; $display("FAIL halt_refetch got %h want %h", obs, W_F0); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_ld_slow();
    test_br();
    test_back_to_back();
    test_random();
    test_reset_wait();
    test_halt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
